button_repeat: RTL and testbench
================================

# button_repeat

Multi-channel debounced button-press detector with hold-to-repeat, used between the raw key/switch inputs and the game control logic (player movement, menu navigation). Each channel emits a single-cycle `press` pulse once its input has been stably high for a debounce window. If repeat is enabled and the input stays high, the channel emits further pulses after an initial delay and then at a fixed period. With `DEB_CYCLES=1` and repeat disabled, a channel behaves as a plain one-pulse-per-press detector.

## Interface
- `N`, default 4: number of independent channels.
- `DEB_CYCLES`, default 4: consecutive high samples required before the first pulse; must be ≥1.
- `DELAY`, default 8: cycles from the initial pulse to the first repeat pulse; must be ≥1.
- `PERIOD`, default 4: cycles between subsequent repeat pulses; must be ≥1.
- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in`  in  N  raw button levels; already synchronous to `clk`, no synchroniser inside.
- `rep_en`  in  N  per-channel auto-repeat enable; level, sampled every cycle.
- `press`  out  N  one-cycle pulse per accepted press or repeat.
- `held`  out  N  registered level, high while a channel is in the accepted-hold states.

## Operation
Per-channel FSM states:
- **IDLE**: counter = 0.
  - `in=1` with `DEB_CYCLES=1` → `press=1`, go to HOLD.
  - `in=1` otherwise → go to DEB with counter = 1.
- **DEB**:
  - `in=0` → IDLE, no pulse.
  - `in=1` on the `DEB_CYCLES`-th consecutive high sample → `press=1`, go to HOLD, clear counter.
  - otherwise → increment counter.
- **HOLD**:
  - `in=0` → IDLE.
  - `rep_en=0` → counter held at 0; stays in HOLD.
  - `rep_en=1` → counter increments; `press=1` in the cycle that is `DELAY` cycles after the initial pulse, then go to REPEAT with counter cleared.
- **REPEAT**:
  - `in=0` → IDLE.
  - `rep_en=0` → go to HOLD with counter = 0, so re-enabling restarts the `DELAY` wait.
  - otherwise → `press=1` every `PERIOD` cycles.

Output rules:
- `press` is Mealy: a function of state, counter, `in`, `rep_en` and `reset`. It is never asserted in a cycle where `in=0`, and it is forced to 0 while `reset=1`.
- `held[i]` = 1 exactly when the registered state is HOLD or REPEAT.
- Channels are fully independent; simultaneous pulses on several channels are legal.
- Counter width is `$clog2(max(DEB_CYCLES, DELAY, PERIOD)+1)`. Counters saturate and never wrap.

## Timing
- Reset: all channels go to IDLE with counters cleared. `press=0` during the reset cycle; `held=0` from the cycle after reset.
- Samples are numbered from the cycle `in` rises (cycle 0). The initial pulse occurs at cycle t0 = `DEB_CYCLES-1`, combinationally in the same cycle as the qualifying sample.
- `held` rises at t0+1. It falls in the cycle after the first `in=0` sample.
- Repeat pulses (with `rep_en` held high) occur at t0+`DELAY`, then t0+`DELAY`+k·`PERIOD` for k ≥ 1.
- Release boundary: a low sample in the same cycle a pulse would fire suppresses that pulse.
- `PERIOD=1`: `press` stays high every cycle while in REPEAT.
- Reset mid-hold: state returns to IDLE. If `in` stays high, the full debounce restarts from the first post-reset sample.

## Structure
- Package `button_pkg`: `btn_state_t` enum (IDLE, DEB, HOLD, REPEAT) and counter-width helper function.
- Sub-module `button_channel`: one FSM plus its counter, scalar `in`/`rep_en`/`press`/`held`, same parameters. The top level instantiates `N` copies through a generate loop.

## Test plan
All scenarios use the default parameters.
- Reset with `in=0` for 5 cycles → `press=0`, `held=0` throughout.
- `in[0]` high for cycles 0–2, then low → no `press`; `held[0]` stays 0.
- `rep_en=0`, `in[0]` high for cycles 0–19 → `press[0]` only at cycle 3; `held[0]` high for cycles 4–20.
- `rep_en[0]=1`, `in[0]` high for cycles 0–19 → `press[0]` at cycles 3, 11, 15, 19; nothing after release; `held[0]=0` from cycle 21.
- `in[1]` rises at cycle 0 and `in[2]` at cycle 2, both held → `press[1]` at 3 and `press[2]` at 5; no cross-channel effect.
- `rep_en=1`, `in[0]` high continuously, `reset` pulsed for one cycle at cycle 9 → no pulse at 9; `held[0]=0` at 10; next `press[0]` at cycle 13.

Source files
------------

// File: rtl/button_pkg.sv
// Shared types and sizing helper for the button debounce/repeat channels.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DEB    = 2'd1,
    HOLD   = 2'd2,
    REPEAT = 2'd3
  } btn_state_t;

  // Counter width large enough for the largest of the three timing parameters.
  function automatic int unsigned cnt_width(input int unsigned deb_cycles,
                                            input int unsigned delay,
                                            input int unsigned period);
    int unsigned m;
    m = deb_cycles;
    if (delay > m) m = delay;
    if (period > m) m = period;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/button_channel.sv
// One debounce + hold-to-repeat channel: FSM with a shared saturating counter.
module button_channel
  import button_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned DELAY      = 8,
  parameter int unsigned PERIOD     = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  input  logic rep_en,
  output logic press,
  output logic held
);

  localparam int unsigned CW = cnt_width(DEB_CYCLES, DELAY, PERIOD);

  // Counter value at which each timed event fires (counter starts at 0 or 1).
  localparam logic [CW-1:0] DEB_LAST    = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] DELAY_LAST  = CW'(DELAY - 1);
  localparam logic [CW-1:0] PERIOD_LAST = CW'(PERIOD - 1);

  btn_state_t    state, state_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;

  assign cnt_inc = (cnt == '1) ? cnt : cnt + CW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    press   = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (in) begin
          if (DEB_CYCLES == 1) begin
            press   = 1'b1;
            state_n = HOLD;
          end else begin
            state_n = DEB;
            cnt_n   = CW'(1);
          end
        end
      end
      DEB: begin
        if (!in) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt >= DEB_LAST) begin
          press   = 1'b1;
          state_n = HOLD;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      HOLD: begin
        if (!in) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (!rep_en) begin
          cnt_n = '0;
        end else if (cnt >= DELAY_LAST) begin
          press   = 1'b1;
          state_n = REPEAT;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      REPEAT: begin
        if (!in) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (!rep_en) begin
          // Dropping repeat returns to HOLD so re-enabling waits DELAY again.
          state_n = HOLD;
          cnt_n   = '0;
        end else if (cnt >= PERIOD_LAST) begin
          press = 1'b1;
          cnt_n = '0;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
    if (reset) press = 1'b0;
  end

  assign held = (state == HOLD) || (state == REPEAT);

endmodule

// File: rtl/button_repeat.sv
// Multi-channel debounced press detector with hold-to-repeat; N independent channels.
module button_repeat
  import button_pkg::*;
#(
  parameter int unsigned N          = 4,
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned DELAY      = 8,
  parameter int unsigned PERIOD     = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] in,
  input  logic [N-1:0] rep_en,
  output logic [N-1:0] press,
  output logic [N-1:0] held
);

  for (genvar i = 0; i < N; i++) begin : g_ch
    button_channel #(
      .DEB_CYCLES (DEB_CYCLES),
      .DELAY      (DELAY),
      .PERIOD     (PERIOD)
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .in     (in[i]),
      .rep_en (rep_en[i]),
      .press  (press[i]),
      .held   (held[i])
    );
  end

endmodule

// File: tb/tb_button_repeat.sv
// Directed bench for button_repeat at default parameters (N=4, DEB=4, DELAY=8, PERIOD=4).
module tb_button_repeat;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] in;
  logic [3:0] rep_en;
  logic [3:0] press;
  logic [3:0] held;

  int unsigned checks = 0;
  int unsigned errors = 0;

  button_repeat #(
    .N          (4),
    .DEB_CYCLES (4),
    .DELAY      (8),
    .PERIOD     (4)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .in     (in),
    .rep_en (rep_en),
    .press  (press),
    .held   (held)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One cycle: inputs applied just after the rising edge, outputs checked at the falling edge.
  task automatic step(input string scn, input int c, input logic rs,
                      input logic [3:0] i, input logic [3:0] r,
                      input logic [3:0] exp_p, input logic [3:0] exp_h);
    @(posedge clk);
    #1;
    reset  = rs;
    in     = i;
    rep_en = r;
    @(negedge clk);
    check($sformatf("%s c%0d press", scn, c), {28'b0, press}, {28'b0, exp_p});
    check($sformatf("%s c%0d held", scn, c), {28'b0, held}, {28'b0, exp_h});
  endtask

  task automatic settle();
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      reset  = 1'b0;
      in     = '0;
      rep_en = '0;
    end
  endtask

  initial begin
    reset  = 1'b1;
    in     = '0;
    rep_en = '0;

    // Reset held for 5 cycles, inputs low.
    for (int c = 0; c < 5; c++) step("reset", c, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0);
    settle();

    // Short glitch: high for 3 samples only.
    for (int c = 0; c < 7; c++)
      step("glitch", c, 1'b0, (c <= 2) ? 4'h1 : 4'h0, 4'h0, 4'h0, 4'h0);
    settle();

    // Hold without repeat.
    for (int c = 0; c < 24; c++)
      step("norep", c, 1'b0, (c <= 19) ? 4'h1 : 4'h0, 4'h0,
           (c == 3) ? 4'h1 : 4'h0,
           (c >= 4 && c <= 20) ? 4'h1 : 4'h0);
    settle();

    // Hold with repeat on channel 0.
    for (int c = 0; c < 25; c++)
      step("rep", c, 1'b0, (c <= 19) ? 4'h1 : 4'h0, 4'h1,
           (c == 3 || c == 11 || c == 15 || c == 19) ? 4'h1 : 4'h0,
           (c >= 4 && c <= 20) ? 4'h1 : 4'h0);
    settle();

    // Release on the cycle a repeat pulse would fire suppresses it.
    for (int c = 0; c < 18; c++)
      step("relbnd", c, 1'b0, (c <= 14) ? 4'h1 : 4'h0, 4'h1,
           (c == 3 || c == 11) ? 4'h1 : 4'h0,
           (c >= 4 && c <= 15) ? 4'h1 : 4'h0);
    settle();

    // Two channels, staggered start, independent.
    for (int c = 0; c < 13; c++) begin
      logic [3:0] iv, ep, eh;
      iv = '0;
      if (c <= 9) iv[1] = 1'b1;
      if (c >= 2 && c <= 9) iv[2] = 1'b1;
      ep = '0;
      if (c == 3) ep[1] = 1'b1;
      if (c == 5) ep[2] = 1'b1;
      eh = '0;
      if (c >= 4 && c <= 10) eh[1] = 1'b1;
      if (c >= 6 && c <= 10) eh[2] = 1'b1;
      step("multi", c, 1'b0, iv, 4'h0, ep, eh);
    end
    settle();

    // Reset pulse mid-hold restarts debounce.
    for (int c = 0; c < 19; c++)
      step("midrst", c, (c == 9), (c <= 16) ? 4'h1 : 4'h0, 4'hF,
           (c == 3 || c == 13) ? 4'h1 : 4'h0,
           ((c >= 4 && c <= 9) || (c >= 14 && c <= 17)) ? 4'h1 : 4'h0);
    settle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
